// File: rtl/hud_text_buffer.sv
// Character-cell buffer for the HUD text overlay: 16x16 cells of 7-bit codes,
// cleared after reset, HP string rendered into HP_ROW, plus a valid/ready
// write port for game logic.
// Latency: char_code is the cell addressed by char_xy on the previous edge.
// Backpressure: wr_ready drops during clear/render and as soon as hp_in
// differs from the displayed value, so the master holds wr_valid.
//
// Ports:
//   clk, rst      pixel clock, asynchronous active-low reset
//   char_xy       read coordinate {row, column}; char_code one cycle later
//   hp_in         hit points 0..15, rendered as "HP" + space + two digits
//   wr_valid/wr_ready/wr_xy/wr_char   external cell write handshake
//   busy          clear or render in progress (or about to start)
module hud_text_buffer #(
  parameter logic [6:0] CLEAR_CHAR = 7'h20,
  parameter logic [3:0] HP_ROW     = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic [3:0] hp_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_xy,
  input  logic [6:0] wr_char,
  output logic       busy
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RENDER} state_t;

  state_t     state, state_n;
  logic [7:0] idx, idx_n;
  logic [2:0] step, step_n;
  logic [3:0] hp_lat, hp_lat_n;
  logic [3:0] hp_shown, hp_shown_n;
  logic       hp_shown_valid, hp_shown_valid_n;
  logic       busy_q, rdy_q;
  logic       pend;
  logic       we;
  logic [7:0] waddr;
  logic [6:0] wdata;
  logic [3:0] ones;

  logic [6:0] mem [0:255];

  // A pending HP change is visible in the same cycle it appears, so it masks
  // the registered ready flag immediately and the render wins over a write
  // presented on that cycle.
  assign pend     = (state == S_IDLE) && (!hp_shown_valid || (hp_in != hp_shown));
  assign busy     = busy_q | pend;
  assign wr_ready = rdy_q & ~pend;

  // Ones digit: hp is at most 15, so one compare-and-subtract replaces mod 10.
  assign ones = (hp_lat >= 4'd10) ? (hp_lat - 4'd10) : hp_lat;

  always_comb begin
    state_n          = state;
    idx_n            = idx;
    step_n           = step;
    hp_lat_n         = hp_lat;
    hp_shown_n       = hp_shown;
    hp_shown_valid_n = hp_shown_valid;
    we               = 1'b0;
    waddr            = 8'h00;
    wdata            = 7'h00;
    case (state)
      S_CLEAR: begin
        we    = 1'b1;
        waddr = idx;
        wdata = CLEAR_CHAR;
        idx_n = idx + 8'd1;
        if (idx == 8'hFF) begin
          state_n          = S_IDLE;
          hp_shown_valid_n = 1'b0;
        end
      end
      S_IDLE: begin
        if (pend) begin
          hp_lat_n = hp_in;
          step_n   = 3'd0;
          state_n  = S_RENDER;
        end else if (wr_valid && wr_ready) begin
          we    = 1'b1;
          waddr = wr_xy;
          wdata = wr_char;
        end
      end
      S_RENDER: begin
        we    = 1'b1;
        waddr = {HP_ROW, 1'b0, step};
        case (step)
          3'd0:    wdata = 7'h48;
          3'd1:    wdata = 7'h50;
          3'd2:    wdata = 7'h20;
          3'd3:    wdata = (hp_lat >= 4'd10) ? 7'h31 : 7'h20;
          default: wdata = 7'h30 + {3'b000, ones};
        endcase
        if (step == 3'd4) begin
          hp_shown_n       = hp_lat;
          hp_shown_valid_n = 1'b1;
          state_n          = S_IDLE;
        end else begin
          step_n = step + 3'd1;
        end
      end
      default: state_n = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_CLEAR;
      idx            <= 8'h00;
      step           <= 3'd0;
      hp_lat         <= 4'd0;
      hp_shown       <= 4'd0;
      hp_shown_valid <= 1'b0;
      busy_q         <= 1'b1;
      rdy_q          <= 1'b0;
      char_code      <= CLEAR_CHAR;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      step           <= step_n;
      hp_lat         <= hp_lat_n;
      hp_shown       <= hp_shown_n;
      hp_shown_valid <= hp_shown_valid_n;
      busy_q         <= (state_n != S_IDLE);
      rdy_q          <= (state_n == S_IDLE) && hp_shown_valid_n;
      // Cell contents are not trustworthy until the clear has swept them.
      char_code      <= (state == S_CLEAR) ? CLEAR_CHAR : mem[char_xy];
    end
  end

  // Storage is not reset; the clear sequence rewrites every cell. Reading and
  // writing the same cell on one edge returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: tb/tb_hud_text_buffer.sv
module tb_hud_text_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_xy;
  logic [6:0] char_code;
  logic [3:0] hp_in;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_xy;
  logic [6:0] wr_char;
  logic       busy;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  // Expected screen: one entry per cell, index row*16 + column.
  int ref_mem [256];

  hud_text_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .char_xy   (char_xy),
    .char_code (char_code),
    .hp_in     (hp_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_xy     (wr_xy),
    .wr_char   (wr_char),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Screen after a clear: every cell holds the space code.
  task automatic model_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = 'h20;
  endtask

  // Screen after rendering hp: "HP " then tens (blank when < 10) and ones.
  task automatic model_render(input int hp);
    ref_mem[0] = 'h48;
    ref_mem[1] = 'h50;
    ref_mem[2] = 'h20;
    ref_mem[3] = (hp / 10 == 1) ? 'h31 : 'h20;
    ref_mem[4] = 'h30 + (hp % 10);
  endtask

  task automatic rd(input int addr, input string tag);
    char_xy = addr[7:0];
    @(negedge clk);
    chk(tag, {25'd0, char_code}, ref_mem[addr]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    #1;
    while (busy && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, {31'd0, busy}, 0);
  endtask

  task automatic wr(input int addr, input int data);
    int n;
    wr_xy    = addr[7:0];
    wr_char  = data[6:0];
    wr_valid = 1'b1;
    n = 0;
    #1;
    while (!wr_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wr_accept_in_time", {31'd0, (n < 50)}, 1);
    @(negedge clk);
    wr_valid = 1'b0;
    ref_mem[addr] = data;
  endtask

  initial begin
    int cnt;
    int a, d, hp, op;
    logic ready_seen, seen35;

    rst      = 1'b1;
    char_xy  = 8'h00;
    hp_in    = 4'd9;
    wr_valid = 1'b0;
    wr_xy    = 8'h00;
    wr_char  = 7'h00;
    #3 rst = 1'b0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_char_code", {25'd0, char_code}, 'h20);
    chk("rst_busy", {31'd0, busy}, 1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 0);

    // Release: clear + decision + render keeps busy high for 262 cycles.
    rst = 1'b1;
    #1;
    cnt = 0;
    ready_seen = 1'b0;
    while (busy && cnt < 400) begin
      if (wr_ready) ready_seen = 1'b1;
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("boot_busy_cycles", cnt, 262);
    chk("boot_ready_low_while_busy", {31'd0, ready_seen}, 0);
    chk("boot_ready_after", {31'd0, wr_ready}, 1);
    model_clear();
    model_render(9);
    for (int i = 0; i < 5; i++) rd(i, "boot_hp_row");
    rd('h10, "boot_row1");

    // HP 9 -> 12 while idle.
    hp_in = 4'd12;
    #1;
    cnt = 0;
    ready_seen = 1'b0;
    while (busy && cnt < 50) begin
      if (wr_ready) ready_seen = 1'b1;
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("hp12_busy_cycles", cnt, 6);
    chk("hp12_ready_low", {31'd0, ready_seen}, 0);
    model_render(12);
    rd(3, "hp12_tens");
    rd(4, "hp12_ones");

    // External write with read-first on the write edge.
    chk("wr_ready_idle", {31'd0, wr_ready}, 1);
    wr_xy    = 8'h25;
    wr_char  = 7'h41;
    wr_valid = 1'b1;
    char_xy  = 8'h25;
    @(negedge clk);
    wr_valid = 1'b0;
    chk("wr_read_first", {25'd0, char_code}, ref_mem['h25]);
    ref_mem['h25] = 'h41;
    @(negedge clk);
    chk("wr_readback", {25'd0, char_code}, ref_mem['h25]);

    // Write raised on the same cycle hp changes 3 -> 10: render goes first.
    hp_in = 4'd3;
    wait_idle("hp3_idle");
    model_render(3);
    @(negedge clk);
    a = $urandom_range(16, 255);
    d = $urandom_range(0, 127);
    hp_in    = 4'd10;
    wr_xy    = a[7:0];
    wr_char  = d[6:0];
    wr_valid = 1'b1;
    #1;
    chk("coll_ready_drops", {31'd0, wr_ready}, 0);
    cnt = 0;
    while (!wr_ready && cnt < 50) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("coll_wait_cycles", cnt, 6);
    @(negedge clk);
    wr_valid = 1'b0;
    model_render(10);
    ref_mem[a] = d;
    rd(3, "coll_tens");
    rd(4, "coll_ones");
    rd(a, "coll_written_cell");

    // Reset asserted at render step 2, held 3 cycles.
    hp_in = 4'd7;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_char_code", {25'd0, char_code}, 'h20);
    chk("midrst_busy", {31'd0, busy}, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    cnt = 0;
    while (busy && cnt < 400) begin
      if (cnt < 256) begin
        chk("midrst_clear_read", {25'd0, char_code}, 'h20);
        char_xy = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      #1;
      cnt++;
    end
    chk("midrst_busy_cycles", cnt, 262);
    model_clear();
    model_render(7);
    rd(4, "midrst_ones");
    rd(3, "midrst_tens");
    rd('h25, "midrst_cell_wiped");

    // HP 5 with change to 6 during render step 1: two renders back to back.
    hp_in = 4'd5;
    wait_idle("hp5_pre_idle");
    model_render(5);
    @(negedge clk);
    hp_in   = 4'd6;
    @(negedge clk);
    hp_in   = 4'd5;
    wait_idle("hp5_idle");
    @(negedge clk);
    char_xy = 8'h04;
    hp_in   = 4'd4;
    #1;
    hp_in   = 4'd5;
    #1;
    cnt = 0;
    seen35 = 1'b0;
    // hp_in is back to the shown value, so restart from a clean change 4 -> 5.
    hp_in = 4'd4;
    wait_idle("hp4_idle");
    @(negedge clk);
    hp_in = 4'd5;
    #1;
    cnt = 0;
    while (busy && cnt < 100) begin
      @(negedge clk);
      cnt++;
      if (cnt == 2) hp_in = 4'd6;
      #1;
      if (char_code === 7'h35) seen35 = 1'b1;
    end
    chk("toggle_busy_cycles", cnt, 12);
    chk("toggle_first_render_35", {31'd0, seen35}, 1);
    model_render(6);
    rd(4, "toggle_final_ones");

    // Randomized mix of writes, reads and HP changes.
    for (int it = 0; it < 80; it++) begin
      op = $urandom_range(0, 9);
      if (op < 4) begin
        wr($urandom_range(0, 255), $urandom_range(0, 127));
      end else if (op < 9) begin
        rd($urandom_range(0, 255), "rand_read");
      end else begin
        hp = $urandom_range(0, 15);
        @(negedge clk);
        hp_in = hp[3:0];
        wait_idle("rand_hp_idle");
        model_render(hp);
        rd($urandom_range(0, 4), "rand_hp_row");
      end
    end
    for (int i = 0; i < 5; i++) rd(i, "final_hp_row");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
